work_loader: RTL and testbench

WORK_LOADER -- requirements
Module: work_loader

---
 rtl/work_loader.sv | 174 +++++++++++++++++
 tb/tb_work_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/work_loader.sv
`default_nettype none
// ============================================================================
// Module      : work_loader
// Description : Assembles a mining work unit from a serial byte stream.
//               Bytes are packed big-endian into 32-bit words; the first
//               MID_WORDS words are shifted into the midstate register and the
//               following REM_WORDS words into the block_data register. When
//               the last word lands, the work is presented as valid until the
//               hashing core acknowledges it or a restart is requested.
// Ports       : clk              - rising-edge clock
//               n_rst            - asynchronous active-low reset
//               rx_data/rx_valid - one received byte per valid cycle
//               start_found      - synchronous abort/restart (highest priority)
//               work_ack         - core has consumed the work (READY only)
//               shift_in_enable  - one-cycle pulse per completed word
//               controller_state - current FSM state
//               midstate         - assembled midstate, first word at the top
//               block_data       - assembled remaining block, first word at top
//               midstate_loaded  - all midstate words captured
//               work_valid       - midstate and block_data complete and stable
//               rx_overrun       - sticky: a byte arrived while in READY
// Revision    : 1.0 - initial release
// ============================================================================
module work_loader #(
   parameter int MID_WORDS = 8,
   parameter int REM_WORDS = 16
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   input  logic                      start_found,
   input  logic                      work_ack,
   output logic                      shift_in_enable,
   output logic [2:0]                controller_state,
   output logic [32*MID_WORDS-1:0]   midstate,
   output logic [32*REM_WORDS-1:0]   block_data,
   output logic                      midstate_loaded,
   output logic                      work_valid,
   output logic                      rx_overrun
);

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      LOAD_MID = 3'b001,
      LOAD_REM = 3'b010,
      READY    = 3'b011
   } state_t;

   // Word indices are compared against the 5-bit word counter.
   localparam logic [4:0] MID_CNT   = 5'(MID_WORDS);
   localparam logic [4:0] MID_LAST  = 5'(MID_WORDS - 1);
   localparam logic [4:0] LAST_WORD = 5'(MID_WORDS + REM_WORDS - 1);

   state_t                   state_q;
   logic [1:0]               byte_cnt_q;
   logic [4:0]               word_cnt_q;
   logic [23:0]              byte_buf_q;
   logic                     shift_q;
   logic [32*MID_WORDS-1:0]  midstate_q;
   logic [32*REM_WORDS-1:0]  block_q;
   logic                     mid_loaded_q;
   logic                     work_valid_q;
   logic                     overrun_q;

   logic [31:0]              word_d;
   logic [32*MID_WORDS-1:0]  mid_shift_d;
   logic [32*REM_WORDS-1:0]  blk_shift_d;

   // The fourth byte completes the word combinationally so the word can be
   // shifted into its target on the same edge that captures that byte.
   always_comb begin
      word_d      = {byte_buf_q, rx_data};
      mid_shift_d = '0;
      blk_shift_d = '0;
      mid_shift_d[31:0] = word_d;
      blk_shift_d[31:0] = word_d;
      for (int i = 1; i < MID_WORDS; i++) begin
         mid_shift_d[32*i +: 32] = midstate_q[32*(i-1) +: 32];
      end
      for (int i = 1; i < REM_WORDS; i++) begin
         blk_shift_d[32*i +: 32] = block_q[32*(i-1) +: 32];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         byte_cnt_q   <= 2'd0;
         word_cnt_q   <= 5'd0;
         byte_buf_q   <= 24'd0;
         shift_q      <= 1'b0;
         midstate_q   <= '0;
         block_q      <= '0;
         mid_loaded_q <= 1'b0;
         work_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         shift_q <= 1'b0;
         if (start_found) begin
            // Restart wins over everything; any partial word is abandoned
            // and the assembled registers keep their last contents.
            state_q      <= IDLE;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= 5'd0;
            mid_loaded_q <= 1'b0;
            work_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (rx_valid) begin
                     byte_buf_q <= {byte_buf_q[15:0], rx_data};
                     byte_cnt_q <= 2'd1;
                     state_q    <= LOAD_MID;
                  end
               end
               LOAD_MID, LOAD_REM: begin
                  if (rx_valid) begin
                     if (byte_cnt_q != 2'd3) begin
                        byte_buf_q <= {byte_buf_q[15:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                     end else begin
                        byte_cnt_q <= 2'd0;
                        word_cnt_q <= word_cnt_q + 5'd1;
                        shift_q    <= 1'b1;
                        if (word_cnt_q < MID_CNT) begin
                           midstate_q <= mid_shift_d;
                        end else begin
                           block_q <= blk_shift_d;
                        end
                        // Terminal count parks in READY, so the counter
                        // never advances beyond the total word count.
                        if (word_cnt_q >= LAST_WORD) begin
                           state_q      <= READY;
                           work_valid_q <= 1'b1;
                           mid_loaded_q <= 1'b1;
                        end else if (word_cnt_q == MID_LAST) begin
                           state_q      <= LOAD_REM;
                           mid_loaded_q <= 1'b1;
                        end
                     end
                  end
               end
               READY: begin
                  if (work_ack) begin
                     state_q      <= IDLE;
                     byte_cnt_q   <= 2'd0;
                     word_cnt_q   <= 5'd0;
                     mid_loaded_q <= 1'b0;
                     work_valid_q <= 1'b0;
                     overrun_q    <= 1'b0;
                  end else if (rx_valid) begin
                     overrun_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign shift_in_enable  = shift_q;
   assign controller_state = state_q;
   assign midstate         = midstate_q;
   assign block_data       = block_q;
   assign midstate_loaded  = mid_loaded_q;
   assign work_valid       = work_valid_q;
   assign rx_overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_work_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_work_loader
// Description : Self-checking bench for work_loader. Stimulus feeds a
//               frame-level reference model and queues one expected record
//               per clock edge; a monitor pops and compares on the falling
//               edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_work_loader;

   localparam int MW = 8;
   localparam int RW = 16;

   logic              clk;
   logic              n_rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              start_found;
   logic              work_ack;
   logic              shift_in_enable;
   logic [2:0]        controller_state;
   logic [32*MW-1:0]  midstate;
   logic [32*RW-1:0]  block_data;
   logic              midstate_loaded;
   logic              work_valid;
   logic              rx_overrun;

   work_loader #(.MID_WORDS(MW), .REM_WORDS(RW)) dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .start_found      (start_found),
      .work_ack         (work_ack),
      .shift_in_enable  (shift_in_enable),
      .controller_state (controller_state),
      .midstate         (midstate),
      .block_data       (block_data),
      .midstate_loaded  (midstate_loaded),
      .work_valid       (work_valid),
      .rx_overrun       (rx_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]       st;
      logic             pulse;
      logic [32*MW-1:0] mid;
      logic [32*RW-1:0] blk;
      logic             ml;
      logic             wv;
      logic             ov;
   } rec_t;

   rec_t        expq[$];
   rec_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          pulse_cnt = 0;

   // Reference model: the bytes of the frame in progress, plus the history
   // of words routed to each output register (oldest at index 0).
   logic [7:0]  frame[$];
   logic [31:0] mid_hist[$];
   logic [31:0] blk_hist[$];
   bit          m_ready;
   bit          m_ovr;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic reset_model();
      frame.delete();
      mid_hist.delete();
      blk_hist.delete();
      for (int i = 0; i < MW; i++) mid_hist.push_back(32'd0);
      for (int i = 0; i < RW; i++) blk_hist.push_back(32'd0);
      m_ready = 0;
      m_ovr   = 0;
   endtask

   function automatic logic [32*MW-1:0] mid_vec();
      logic [32*MW-1:0] v;
      for (int i = 0; i < MW; i++) v[32*(MW-1-i) +: 32] = mid_hist[i];
      return v;
   endfunction

   function automatic logic [32*RW-1:0] blk_vec();
      logic [32*RW-1:0] v;
      for (int i = 0; i < RW; i++) v[32*(RW-1-i) +: 32] = blk_hist[i];
      return v;
   endfunction

   // Applies one cycle of inputs, advances the model and queues the
   // expected post-edge outputs.
   task automatic cycle(input logic v, input logic [7:0] d, input logic sf, input logic ack);
      rec_t        r;
      int          n;
      logic [31:0] w;
      rx_valid    = v;
      rx_data     = d;
      start_found = sf;
      work_ack    = ack;
      r.pulse     = 1'b0;
      if (sf) begin
         frame.delete();
         m_ready = 0;
         m_ovr   = 0;
      end else if (m_ready) begin
         if (ack) begin
            frame.delete();
            m_ready = 0;
            m_ovr   = 0;
         end else if (v) begin
            m_ovr = 1;
         end
      end else if (v) begin
         frame.push_back(d);
         n = frame.size();
         if (n % 4 == 0) begin
            r.pulse = 1'b1;
            w = {frame[n-4], frame[n-3], frame[n-2], frame[n-1]};
            if (n / 4 - 1 < MW) begin
               mid_hist.push_back(w);
               mid_hist.delete(0);
            end else begin
               blk_hist.push_back(w);
               blk_hist.delete(0);
            end
            if (n == 4 * (MW + RW)) m_ready = 1;
         end
      end
      n = frame.size();
      r.st  = m_ready ? 3'b011 : (n == 0 ? 3'b000 : (n < 4 * MW ? 3'b001 : 3'b010));
      r.ml  = m_ready || (n >= 4 * MW);
      r.wv  = m_ready;
      r.ov  = m_ovr;
      r.mid = mid_vec();
      r.blk = blk_vec();
      @(posedge clk);
      expq.push_back(r);
      #1;
      rx_valid    = 1'b0;
      start_found = 1'b0;
      work_ack    = 1'b0;
   endtask

   // Streams n bytes, optionally with idle gaps (and stray acks) between them.
   task automatic stream(input int n, input bit seq, input bit gaps, input bit rand_ack);
      int g;
      for (int i = 0; i < n; i++) begin
         g = gaps ? int'($urandom_range(0, 2)) : 0;
         for (int j = 0; j < g; j++) begin
            cycle(1'b0, 8'($urandom), 1'b0, rand_ack && ($urandom_range(0, 3) == 0));
         end
         cycle(1'b1, seq ? 8'(i) : 8'($urandom), 1'b0, 1'b0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " sie"}, 512'(shift_in_enable), 512'd0);
      chk({tag, " state"}, 512'(controller_state), 512'd0);
      chk({tag, " midstate"}, 512'(midstate), 512'd0);
      chk({tag, " block"}, 512'(block_data), 512'd0);
      chk({tag, " mid_loaded"}, 512'(midstate_loaded), 512'd0);
      chk({tag, " work_valid"}, 512'(work_valid), 512'd0);
      chk({tag, " overrun"}, 512'(rx_overrun), 512'd0);
   endtask

   // Monitor: one expected record per clock edge, compared mid-cycle.
   always @(negedge clk) begin
      if (shift_in_enable === 1'b1) pulse_cnt++;
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         chk("state", 512'(controller_state), 512'(mon_e.st));
         chk("sie", 512'(shift_in_enable), 512'(mon_e.pulse));
         chk("midstate", 512'(midstate), 512'(mon_e.mid));
         chk("block", 512'(block_data), 512'(mon_e.blk));
         chk("mid_loaded", 512'(midstate_loaded), 512'(mon_e.ml));
         chk("work_valid", 512'(work_valid), 512'(mon_e.wv));
         chk("overrun", 512'(rx_overrun), 512'(mon_e.ov));
      end
   end

   initial begin
      rx_valid    = 1'b0;
      rx_data     = 8'd0;
      start_found = 1'b0;
      work_ack    = 1'b0;
      n_rst       = 1'b1;
      reset_model();
      #1 n_rst = 1'b0;
      #2 chk_all_zero("por");
      @(posedge clk);
      @(posedge clk);
      #2 n_rst = 1'b1;
      #1;

      // Sequential 96-byte frame, continuous valid.
      pulse_cnt = 0;
      stream(4 * (MW + RW), 1'b1, 1'b0, 1'b0);
      #5;
      chk("pulse count", 512'(pulse_cnt), 512'd24);
      chk("mid top word", 512'(midstate[255:224]), 512'h00010203);
      chk("blk low word", 512'(block_data[31:0]), 512'h5C5D5E5F);
      chk("frame ready", 512'(controller_state), 512'd3);
      chk("frame valid", 512'(work_valid), 512'd1);

      // Extra byte while READY, then acknowledge.
      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      #5;
      chk("ack idle", 512'(controller_state), 512'd0);
      chk("ack mid held", 512'(midstate[255:224]), 512'h00010203);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);

      // Abort after 50 bytes (coincident byte must be dropped), then refill.
      stream(50, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 8'h77, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      stream(4 * (MW + RW), 1'b0, 1'b1, 1'b1);

      // Restart, ack and byte together while READY.
      cycle(1'b1, 8'h55, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset mid-word, between clock edges.
      stream(6, 1'b0, 1'b0, 1'b0);
      #5 n_rst = 1'b0;
      #1 chk_all_zero("async rst");
      #1 n_rst = 1'b1;
      reset_model();

      // Random frames with stray acks, overruns and acknowledges.
      for (int k = 0; k < 3; k++) begin
         stream(4 * (MW + RW), 1'b0, 1'b1, 1'b1);
         if ($urandom_range(0, 1) == 1) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
         cycle(1'b0, 8'h00, 1'b0, 1'b1);
      end
      stream(21, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      #6;
      chk("queue drained", 512'(expq.size()), 512'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
